fetch_stage: RTL and testbench

Pipeline fetch (F) stage: owns the program counter and the F/D pipeline register. Each cycle it addresses instruction memory and captures `{PC+2, instruction}` into F/D, which drives the decode stage's `D_in[31:0]`. It consumes decode's branch-resolution outputs (`flush`, `branch_target`, `halt_PC`) and the hazard unit's `stall`. It inserts bubbles on taken branches and on halt.

---
 rtl/fetch_stage.sv | 41 ++++
 tb/tb_fetch_stage.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: PC register and F/D pipeline register with stall, branch-flush and halt bubbles
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'hA000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] branch_target,
  input  logic        halt_PC,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [31:0] F_out,
  output logic [15:0] pc_out,
  output logic        halted,
  output logic [15:0] fetch_count
);
  logic [15:0] pc, pc_plus_2, pc_nxt;
  logic [31:0] fd, fd_nxt;
  logic        bubble;
  assign pc_plus_2 = pc + 16'd2;
  assign bubble    = halted | flush | halt_PC;
  assign pc_nxt    = halted ? pc : flush ? branch_target : halt_PC ? pc : pc_plus_2;
  assign fd_nxt    = bubble ? {16'h0000, NOP_INSTR} : {pc_plus_2, imem_data};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc          <= RESET_PC;
      fd          <= {16'h0000, NOP_INSTR};
      halted      <= 1'b0;
      fetch_count <= 16'h0000;
    end else if (!stall) begin
      pc          <= pc_nxt;
      fd          <= fd_nxt;
      halted      <= halted | (halt_PC & ~flush);
      fetch_count <= bubble ? fetch_count : fetch_count + 16'd1;
    end
  assign imem_addr = pc;
  assign pc_out    = pc;
  assign F_out     = fd;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized fetch stimulus checked against a behavioural fetch model
module tb_fetch_stage;
  localparam logic [31:0] BUB = 32'h0000_A000;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall = 1'b0, flush = 1'b0, halt_PC = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic [15:0] imem_addr, imem_data, pc_out, fetch_count;
  logic [31:0] F_out;
  logic        halted;
  logic [15:0] mem [32768];
  logic [15:0] m_pc, m_cnt;
  logic [31:0] m_fd;
  logic        m_halted;
  int          errors = 0, checks = 0;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .branch_target(branch_target), .halt_PC(halt_PC), .imem_addr(imem_addr),
    .imem_data(imem_data), .F_out(F_out), .pc_out(pc_out), .halted(halted),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;
  assign imem_data = mem[imem_addr[15:1]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_fd = BUB; m_halted = 1'b0; m_cnt = 16'h0000;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"}, {16'h0, pc_out}, {16'h0, m_pc});
    chk({tag, ".imem_addr"}, {16'h0, imem_addr}, {16'h0, m_pc});
    chk({tag, ".F_out"}, F_out, m_fd);
    chk({tag, ".halted"}, {31'h0, halted}, {31'h0, m_halted});
    chk({tag, ".fetch_count"}, {16'h0, fetch_count}, {16'h0, m_cnt});
  endtask

  task automatic step(input logic s, input logic f, input logic h, input logic [15:0] t,
                      input bit quiet = 1'b0);
    logic [15:0] instr, seq;
    stall = s; flush = f; halt_PC = h; branch_target = t;
    instr = mem[m_pc[15:1]];
    seq = m_pc + 16'd2;
    @(posedge clk);
    #1;
    if (!s) begin
      if (m_halted) m_fd = BUB;
      else if (f) begin m_pc = t; m_fd = BUB; end
      else if (h) begin m_fd = BUB; m_halted = 1'b1; end
      else begin m_pc = seq; m_fd = {seq, instr}; m_cnt = m_cnt + 16'd1; end
    end
    if (!quiet) check_all("step");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1123;
    mem[1] = 16'h2456;
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("rst.imem_addr", {16'h0, imem_addr}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_all("rst");
    chk("rst.F_out_bubble", F_out, BUB);
    @(negedge clk);
    rst_n = 1'b1;

    step(0, 0, 0, 0);
    chk("seq1.F_out", F_out, 32'h0002_1123);
    chk("seq1.pc", {16'h0, pc_out}, 32'h2);
    step(0, 0, 0, 0);
    chk("seq2.F_out", F_out, 32'h0004_2456);
    chk("seq2.cnt", {16'h0, fetch_count}, 32'h2);
    repeat (6) step(0, 0, 0, 0);
    chk("pre_stall.pc", {16'h0, pc_out}, 32'h10);

    for (int i = 0; i < 3; i++) begin
      step(1, 1'($urandom), 1'($urandom), 16'($urandom) & 16'hFFFE);
      chk("stall.pc", {16'h0, pc_out}, 32'h10);
      chk("stall.cnt", {16'h0, fetch_count}, 32'h8);
    end
    step(0, 0, 0, 0);
    chk("unstall.F_out", F_out, {16'h0012, mem[16'h0010 >> 1]});

    repeat (7) step(0, 0, 0, 0);
    chk("pre_br.pc", {16'h0, pc_out}, 32'h20);
    step(0, 1, 0, 16'h0100);
    chk("br.F_out", F_out, BUB);
    chk("br.pc", {16'h0, pc_out}, 32'h100);
    step(0, 0, 0, 0);
    chk("br_tgt.F_out", F_out, {16'h0102, mem[16'h0100 >> 1]});

    step(0, 1, 0, 16'h0030);
    step(0, 0, 1, 0);
    chk("halt.halted", {31'h0, halted}, 32'h1);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1'($urandom), 16'($urandom) & 16'hFFFE);
      chk("halt.pc", {16'h0, pc_out}, 32'h30);
      chk("halt.F_out", F_out, BUB);
    end
    step(0, 1, 0, 16'h0200);
    chk("halt_flush.pc", {16'h0, pc_out}, 32'h30);
    do_reset();
    chk("rst_mid.halted", {31'h0, halted}, 32'h0);

    step(1, 1, 0, 16'h0400);
    chk("prio.pc", {16'h0, pc_out}, 32'h0);
    step(0, 1, 0, 16'h0400);
    chk("prio2.pc", {16'h0, pc_out}, 32'h400);

    for (int i = 0; i < 300; i++) begin
      if (m_halted && $urandom_range(0, 7) == 0) do_reset();
      else step($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 19) == 0, 16'($urandom) & 16'hFFFE);
    end
    do_reset();

    step(0, 1, 0, 16'hFFFE);
    step(0, 0, 0, 0);
    chk("wrap.pc", {16'h0, pc_out}, 32'h0);
    chk("wrap.F_hi", {16'h0, F_out[31:16]}, 32'h0);

    do_reset();
    for (int i = 0; i < 65535; i++) step(0, 0, 0, 0, 1'b1);
    check_all("cnt_ffff");
    chk("cnt.ffff", {16'h0, fetch_count}, 32'hFFFF);
    step(0, 0, 0, 0);
    chk("cnt.wrap", {16'h0, fetch_count}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
